// File: rtl/line_memory_responder.sv
// rtl/line_memory_responder.sv - main-memory line responder with fixed access latency
//
// Purpose: responder end of the cache-to-memory interface. Holds DEPTH_LINES
// 128-bit lines and completes one access (line fill or writeback) at a time,
// LATENCY cycles after the request is accepted.
//
// Optional feature macro: MEM_RANGE_CHECK_EN
//   defined   - address bits above the line-index field must be zero; an
//               out-of-range access reports resp_err, suppresses the write and
//               returns zero read data.
//   undefined - resp_err is tied low and addresses wrap modulo DEPTH_LINES.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   req_valid  in   request present
//   req_write  in   1 = line write, 0 = line read
//   req_addr   in   byte address; [3:0] ignored, line index at [4 +: log2(DEPTH_LINES)]
//   req_wdata  in   write line data
//   req_ready  out  high in IDLE
//   busy       out  high while an access is in flight (WAIT or RESP)
//   count      out  cycles elapsed in the current access
//   resp_valid out  one-cycle completion pulse
//   resp_rdata out  last read line, held until the next read completes
//   resp_err   out  out-of-range flag, valid with resp_valid

module line_memory_responder #(
  parameter int LATENCY     = 20,
  parameter int DEPTH_LINES = 256
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid,
  input  logic         req_write,
  input  logic [31:0]  req_addr,
  input  logic [127:0] req_wdata,
  output logic         req_ready,
  output logic         busy,
  output logic [4:0]   count,
  output logic         resp_valid,
  output logic [127:0] resp_rdata,
  output logic         resp_err
);

  localparam int         IDX_W      = $clog2(DEPTH_LINES);
  localparam logic [4:0] LAST_COUNT = 5'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t state;
  state_t state_next;

  logic             write_q;
  logic [IDX_W-1:0] idx_q;
  logic [127:0]     wdata_q;
  logic             err_q;
  logic             resp_err_q;

  logic             accept;
  logic             access;
  logic             req_oor;

  // Line storage: deliberately outside the reset domain so contents survive reset.
  logic [127:0]     mem [DEPTH_LINES];

`ifdef MEM_RANGE_CHECK_EN
  localparam logic [31:0] UPPER_MASK = ~((32'd1 << (4 + IDX_W)) - 32'd1);
  assign req_oor  = |(req_addr & UPPER_MASK);
  assign resp_err = resp_err_q;
  logic unused_addr;
  assign unused_addr = ^req_addr[3:0];
`else
  assign req_oor  = 1'b0;
  assign resp_err = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{req_addr, resp_err_q};
`endif

  assign accept = (state == ST_IDLE) && req_valid;
  // Single edge at which the array is written or read: last WAIT cycle.
  assign access = (state == ST_WAIT) && (count == LAST_COUNT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (count == LAST_COUNT) state_next = ST_RESP;
      end
      ST_RESP: begin
        busy       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count      <= 5'd0;
      write_q    <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err_q <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_err_q <= 1'b0;
      if (accept) begin
        write_q <= req_write;
        idx_q   <= req_addr[4 +: IDX_W];
        wdata_q <= req_wdata;
        err_q   <= req_oor;
        count   <= 5'd0;
      end else if (access) begin
        count      <= 5'd0;
        resp_valid <= 1'b1;
        resp_err_q <= err_q;
        // Writes leave read data alone unless the access was rejected.
        if (err_q) begin
          resp_rdata <= '0;
        end else if (!write_q) begin
          resp_rdata <= mem[idx_q];
        end
      end else if (state == ST_WAIT) begin
        count <= count + 5'd1;
      end else begin
        count <= 5'd0;
      end
    end
  end

  // state is held in IDLE during reset, so an interrupted write never reaches here.
  always_ff @(posedge clk) begin
    if (access && write_q && !err_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_line_memory_responder.sv
// tb/tb_line_memory_responder.sv - scoreboard bench for line_memory_responder

module tb_line_memory_responder;

  localparam int LAT = 20;

  logic         clk;
  logic         reset_n;
  logic         req_valid;
  logic         req_write;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;
  logic         req_ready;
  logic         busy;
  logic [4:0]   count;
  logic         resp_valid;
  logic [127:0] resp_rdata;
  logic         resp_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [127:0] rd;
    logic         err;
    int           at;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [127:0] DATA_9 = 128'h9;
  localparam logic [127:0] DATA_A = 128'hA5A5_0001_A5A5_0002_A5A5_0003_A5A5_0004;
  localparam logic [127:0] DATA_B = 128'h0BB0_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [127:0] DATA_C = 128'hCCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC;
  localparam logic [127:0] DATA_D = 128'hDEAD_BEEF_0000_0000_1234_5678_9ABC_DEF0;

  line_memory_responder #(.LATENCY(LAT), .DEPTH_LINES(256)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .busy       (busy),
    .count      (count),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response (cyc %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rd);
        chk("resp_err", 128'(resp_err), 128'(e.err));
        chk("resp_cycle", 128'(cyc), 128'(e.at));
      end
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_req_ready"}, 128'(req_ready), 128'd1);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_count"}, 128'(count), 128'd0);
    chk({tag, "_resp_valid"}, 128'(resp_valid), 128'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 128'd0);
    chk({tag, "_resp_err"}, 128'(resp_err), 128'd0);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 4 * LAT; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && req_ready === 1'b1) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [127:0] wd,
                        input logic [127:0] exp_rd, input bit exp_err, input bit chk_count);
    int c0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    c0 = cyc;
    exp_q.push_back('{rd: exp_rd, err: exp_err, at: c0 + LAT});
    req_valid = 1'b0;
    chk("req_ready_after_accept", 128'(req_ready), 128'd0);
    chk("busy_after_accept", 128'(busy), 128'd1);
    if (chk_count) begin
      for (int k = 0; k < LAT; k++) begin
        @(negedge clk);
        chk("count_wait", 128'(count), 128'(k));
        chk("resp_valid_early", 128'(resp_valid), 128'd0);
      end
      @(negedge clk);
      chk("count_resp", 128'(count), 128'd0);
      chk("resp_valid_pulse", 128'(resp_valid), 128'd1);
    end
    wait_drain();
  endtask

  initial begin
    bit hit;
    int c0;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'd0;
    req_wdata = '0;
    repeat (2) @(negedge clk);
    check_reset_state("rst");
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_state("post_rst");

    // Write line 0 with count and pulse timing checks, then read it back.
    do_req(1'b1, 32'h0000_0000, DATA_9, 128'd0, 1'b0, 1'b1);
    do_req(1'b0, 32'h0000_0000, '0, DATA_9, 1'b0, 1'b0);

    // Offset bits [3:0] are ignored.
    do_req(1'b1, 32'h0000_0010, DATA_A, DATA_9, 1'b0, 1'b0);
    do_req(1'b0, 32'h0000_001C, '0, DATA_A, 1'b0, 1'b0);

    // Commit B to line 2, then abort a write of C to the same line with reset.
    do_req(1'b1, 32'h0000_0020, DATA_B, DATA_A, 1'b0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_0020;
    req_wdata = DATA_C;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(negedge clk);
      if (count == 5'd10) begin
        hit = 1'b1;
        break;
      end
    end
    chk("abort_reached_count10", 128'(hit), 128'd1);
    reset_n = 1'b0;
    #1;
    check_reset_state("mid_rst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    chk("no_resp_after_abort", 128'(resp_valid), 128'd0);
    do_req(1'b0, 32'h0000_0020, '0, DATA_B, 1'b0, 1'b0);

    // req_valid held high: accepts every LAT+2 cycles, ignored while busy.
    @(negedge clk);
    c0 = cyc + 1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0000_0014;
    for (int n = 0; n < 3; n++) begin
      exp_q.push_back('{rd: DATA_A, err: 1'b0, at: c0 + LAT + n * (LAT + 2)});
    end
    for (int i = 0; i < 5 * LAT; i++) begin
      @(negedge clk);
      if (cyc == c0 + 10) chk("b2b_busy_mid", 128'(req_ready), 128'd0);
      if (cyc >= c0 + LAT + 2 * (LAT + 2)) break;
    end
    req_valid = 1'b0;
    wait_drain();

    // Address above the index field.
`ifdef MEM_RANGE_CHECK_EN
    do_req(1'b1, 32'h0000_1000, DATA_D, 128'd0, 1'b1, 1'b0);
    do_req(1'b0, 32'h0000_0000, '0, DATA_9, 1'b0, 1'b0);
`else
    do_req(1'b1, 32'h0000_1000, DATA_D, DATA_A, 1'b0, 1'b0);
    do_req(1'b0, 32'h0000_0000, '0, DATA_D, 1'b0, 1'b0);
`endif

    repeat (3) @(negedge clk);
    chk("final_queue_empty", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
